// File: rtl/ihex_decoder_if.sv
// Character stream in, single-byte memory writes out.
interface ihex_decoder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              we_in;
    logic [7:0]        data_in;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output we_in,
        output data_in,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  we_in,
        input  data_in,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/ihex_decoder.sv
// Intel HEX record parser: turns data records into byte write strobes,
// checks record checksums and tracks the extended linear (upper) address.
module ihex_decoder #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic           clock,
    input  logic           reset,
    ihex_decoder_if.slave  bus,
    output logic           done,
    output logic           err_checksum,
    output logic           err_format
);

    localparam int unsigned FULL_W = 32;
    localparam logic [7:0]  COLON  = 8'h3A;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        ADDR_HI,
        ADDR_LO,
        TYPE,
        DATA,
        CSUM
    } state_t;

    state_t      state;
    logic        nib_flag;     // high nibble of the current byte already captured
    logic [3:0]  hi_nib;
    logic [7:0]  sum;
    logic [7:0]  len;
    logic [15:0] rec_addr;
    logic [7:0]  rec_type;
    logic [7:0]  idx;
    logic [15:0] pend_upper;   // type-04 payload, committed only on a good checksum
    logic [15:0] upper;

    logic [4:0]  hex_c;
    logic [7:0]  byte_c;
    logic [7:0]  sum_next_c;
    logic [7:0]  idx_next_c;
    logic [15:0] wr_low_c;
    logic [FULL_W-1:0] wr_full_c;

    // Map an ASCII hex digit to {valid, value}.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, 4'(c - 8'h30)};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, 4'(c - 8'h37)};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            r = {1'b1, 4'(c - 8'h57)};
        end
        return r;
    endfunction

    // Byte assembly, running sum and write address for the current character.
    always_comb begin
        hex_c      = hex_decode(bus.data_in);
        byte_c     = {hi_nib, hex_c[3:0]};
        sum_next_c = 8'(sum + byte_c);
        idx_next_c = 8'(idx + 8'd1);
        wr_low_c   = 16'(rec_addr + 16'(idx));
        wr_full_c  = {upper, wr_low_c};
    end

    // Record parser FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            nib_flag     <= 1'b0;
            hi_nib       <= 4'd0;
            sum          <= 8'd0;
            len          <= 8'd0;
            rec_addr     <= 16'd0;
            rec_type     <= 8'd0;
            idx          <= 8'd0;
            pend_upper   <= 16'd0;
            upper        <= 16'd0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= 8'd0;
            done         <= 1'b0;
            err_checksum <= 1'b0;
            err_format   <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            if (bus.we_in) begin
                if (bus.data_in == COLON) begin
                    // A colon always starts a fresh record; mid-record it means truncation.
                    if (state != IDLE) begin
                        err_format <= 1'b1;
                    end
                    done     <= 1'b0;
                    sum      <= 8'd0;
                    nib_flag <= 1'b0;
                    idx      <= 8'd0;
                    state    <= LEN;
                end else if (state == IDLE) begin
                    state <= IDLE;
                end else if (!hex_c[4]) begin
                    err_format <= 1'b1;
                    nib_flag   <= 1'b0;
                    state      <= IDLE;
                end else if (!nib_flag) begin
                    hi_nib   <= hex_c[3:0];
                    nib_flag <= 1'b1;
                end else begin
                    nib_flag <= 1'b0;
                    sum      <= sum_next_c;
                    unique case (state)
                        LEN: begin
                            len   <= byte_c;
                            state <= ADDR_HI;
                        end
                        ADDR_HI: begin
                            rec_addr[15:8] <= byte_c;
                            state          <= ADDR_LO;
                        end
                        ADDR_LO: begin
                            rec_addr[7:0] <= byte_c;
                            state         <= TYPE;
                        end
                        TYPE: begin
                            rec_type <= byte_c;
                            if (byte_c > 8'h05 ||
                                (byte_c == 8'h01 && len != 8'd0) ||
                                (byte_c == 8'h04 && len != 8'd2)) begin
                                err_format <= 1'b1;
                                state      <= IDLE;
                            end else if (len != 8'd0) begin
                                state <= DATA;
                            end else begin
                                state <= CSUM;
                            end
                        end
                        DATA: begin
                            if (rec_type == 8'h00) begin
                                bus.mem_we   <= 1'b1;
                                bus.mem_addr <= ADDR_W'(wr_full_c);
                                bus.mem_data <= byte_c;
                            end else if (rec_type == 8'h04) begin
                                if (idx == 8'd0) begin
                                    pend_upper[15:8] <= byte_c;
                                end else begin
                                    pend_upper[7:0] <= byte_c;
                                end
                            end
                            idx <= idx_next_c;
                            if (idx_next_c == len) begin
                                state <= CSUM;
                            end
                        end
                        CSUM: begin
                            if (sum_next_c != 8'd0) begin
                                err_checksum <= 1'b1;
                            end else if (rec_type == 8'h01) begin
                                done <= 1'b1;
                            end else if (rec_type == 8'h04) begin
                                upper <= pend_upper;
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ihex_decoder.sv
// Directed bench for ihex_decoder, 16-bit and 32-bit address builds side by side.
module tb_ihex_decoder;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    logic done16, err_cs16, err_fmt16;
    logic done32, err_cs32, err_fmt32;

    ihex_decoder_if #(.ADDR_W(16)) bus16 ();
    ihex_decoder_if #(.ADDR_W(32)) bus32 ();

    ihex_decoder #(.ADDR_W(16)) dut16 (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus16.slave),
        .done         (done16),
        .err_checksum (err_cs16),
        .err_format   (err_fmt16)
    );

    ihex_decoder #(.ADDR_W(32)) dut32 (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus32.slave),
        .done         (done32),
        .err_checksum (err_cs32),
        .err_format   (err_fmt32)
    );

    logic [31:0] q16_addr[$];
    logic [7:0]  q16_data[$];
    int          q16_cyc[$];
    logic [31:0] q32_addr[$];
    logic [7:0]  q32_data[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every write strobe seen on either build.
    always @(negedge clock) begin
        if (bus16.mem_we === 1'b1) begin
            q16_addr.push_back({16'd0, bus16.mem_addr});
            q16_data.push_back(bus16.mem_data);
            q16_cyc.push_back(cyc);
        end
        if (bus32.mem_we === 1'b1) begin
            q32_addr.push_back(bus32.mem_addr);
            q32_data.push_back(bus32.mem_data);
        end
    end

    task automatic drive(input int sel, input logic we, input logic [7:0] c);
        if (sel == 0) begin
            bus16.we_in   = we;
            bus16.data_in = c;
        end else begin
            bus32.we_in   = we;
            bus32.data_in = c;
        end
    endtask

    // Returns at the sampling point of the cycle after the last character is taken.
    task automatic send_str(input int sel, input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clock);
            drive(sel, 1'b1, s[i]);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                drive(sel, 1'b0, 8'h00);
            end
        end
        @(negedge clock);
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        idle(2);
        reset = 1'b0;
        q16_addr.delete(); q16_data.delete(); q16_cyc.delete();
        q32_addr.delete(); q32_data.delete();
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(0, 1'b1, 8'h3A);
        drive(1, 1'b1, 8'h3A);
        idle(2);
        checks++;
        if ({bus16.mem_we, bus16.mem_addr, bus16.mem_data, done16, err_cs16, err_fmt16} !== 28'd0) begin
            errors++;
            $display("FAIL reset16 outputs got we=%b addr=%h data=%h done=%b cs=%b fmt=%b want all 0",
                     bus16.mem_we, bus16.mem_addr, bus16.mem_data, done16, err_cs16, err_fmt16);
        end
        checks++;
        if ({bus32.mem_we, bus32.mem_addr, bus32.mem_data, done32, err_cs32, err_fmt32} !== 44'd0) begin
            errors++;
            $display("FAIL reset32 outputs got we=%b addr=%h data=%h done=%b cs=%b fmt=%b want all 0",
                     bus32.mem_we, bus32.mem_addr, bus32.mem_data, done32, err_cs32, err_fmt32);
        end
        do_reset();
    endtask

    task automatic test_data_record();
        do_reset();
        send_str(0, ":0300100011223387", 1);
        idle(3);
        checks++;
        if (q16_addr.size() != 3 ||
            q16_addr[0] !== 32'h0010 || q16_data[0] !== 8'h11 ||
            q16_addr[1] !== 32'h0011 || q16_data[1] !== 8'h22 ||
            q16_addr[2] !== 32'h0012 || q16_data[2] !== 8'h33) begin
            errors++;
            $display("FAIL data_record writes got n=%0d first=(%h,%h) want 3 writes (0010,11)(0011,22)(0012,33)",
                     q16_addr.size(), (q16_addr.size() > 0) ? q16_addr[0] : 32'hx,
                     (q16_data.size() > 0) ? q16_data[0] : 8'hx);
        end
        checks++;
        if ({err_cs16, err_fmt16, done16} !== 3'b000) begin
            errors++;
            $display("FAIL data_record flags got cs=%b fmt=%b done=%b want 0 0 0", err_cs16, err_fmt16, done16);
        end
    endtask

    task automatic test_eof();
        do_reset();
        send_str(0, ":00000001FF", 0);
        checks++;
        if (done16 !== 1'b1) begin
            errors++;
            $display("FAIL eof_done got %b want 1", done16);
        end
        checks++;
        if (q16_addr.size() != 0 || err_cs16 !== 1'b0 || err_fmt16 !== 1'b0) begin
            errors++;
            $display("FAIL eof_side got writes=%0d cs=%b fmt=%b want 0 0 0", q16_addr.size(), err_cs16, err_fmt16);
        end
        send_str(0, ":", 0);
        checks++;
        if (done16 !== 1'b0) begin
            errors++;
            $display("FAIL eof_clear got done=%b want 0", done16);
        end
        send_str(0, "0100000055AA", 0);
        idle(2);
        checks++;
        if (q16_addr.size() != 1 || q16_addr[0] !== 32'h0000 || q16_data[0] !== 8'h55 || err_fmt16 !== 1'b0) begin
            errors++;
            $display("FAIL eof_next_record got n=%0d fmt=%b want one write (0000,55) fmt=0", q16_addr.size(), err_fmt16);
        end
    endtask

    task automatic test_checksum_error();
        do_reset();
        send_str(0, ":0100000055AB", 0);
        checks++;
        if (err_cs16 !== 1'b1 || done16 !== 1'b0) begin
            errors++;
            $display("FAIL csum_flags got cs=%b done=%b want cs=1 done=0", err_cs16, done16);
        end
        idle(2);
        checks++;
        if (q16_addr.size() != 1 || q16_addr[0] !== 32'h0000 || q16_data[0] !== 8'h55) begin
            errors++;
            $display("FAIL csum_write got n=%0d want one write (0000,55)", q16_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_str(0, ":02FFFF00aabb9B", 0);
        idle(2);
        checks++;
        if (q16_addr.size() != 2 ||
            q16_addr[0] !== 32'hFFFF || q16_data[0] !== 8'hAA ||
            q16_addr[1] !== 32'h0000 || q16_data[1] !== 8'hBB) begin
            errors++;
            $display("FAIL b2b_writes got n=%0d want (FFFF,AA)(0000,BB)", q16_addr.size());
        end
        checks++;
        if (q16_cyc.size() != 2 || (q16_cyc[1] - q16_cyc[0]) != 2) begin
            errors++;
            $display("FAIL b2b_spacing got n=%0d gap=%0d want 2 writes 2 cycles apart", q16_cyc.size(),
                     (q16_cyc.size() == 2) ? (q16_cyc[1] - q16_cyc[0]) : -1);
        end
        checks++;
        if ({err_cs16, err_fmt16} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_flags got cs=%b fmt=%b want 0 0", err_cs16, err_fmt16);
        end
    endtask

    task automatic test_ext_addr();
        do_reset();
        send_str(1, ":020000040001F9", 0);
        send_str(1, ":0100000055AA", 0);
        idle(2);
        checks++;
        if (q32_addr.size() != 1 || q32_addr[0] !== 32'h0001_0000 || q32_data[0] !== 8'h55) begin
            errors++;
            $display("FAIL ext_addr_good got n=%0d addr=%h want one write (00010000,55)", q32_addr.size(),
                     (q32_addr.size() > 0) ? q32_addr[0] : 32'hx);
        end
        checks++;
        if ({err_cs32, err_fmt32} !== 2'b00) begin
            errors++;
            $display("FAIL ext_addr_flags got cs=%b fmt=%b want 0 0", err_cs32, err_fmt32);
        end
        do_reset();
        send_str(1, ":020000040001F8", 0);
        checks++;
        if (err_cs32 !== 1'b1) begin
            errors++;
            $display("FAIL ext_addr_bad_cs got %b want 1", err_cs32);
        end
        send_str(1, ":0100000055AA", 0);
        idle(2);
        checks++;
        if (q32_addr.size() != 1 || q32_addr[0] !== 32'h0000_0000 || q32_data[0] !== 8'h55) begin
            errors++;
            $display("FAIL ext_addr_bad_write got n=%0d addr=%h want one write (00000000,55)", q32_addr.size(),
                     (q32_addr.size() > 0) ? q32_addr[0] : 32'hx);
        end
    endtask

    task automatic test_format_error();
        do_reset();
        send_str(0, ":01G0", 0);
        checks++;
        if (err_fmt16 !== 1'b1 || q16_addr.size() != 0) begin
            errors++;
            $display("FAIL fmt_bad_char got fmt=%b writes=%0d want fmt=1 writes=0", err_fmt16, q16_addr.size());
        end
        send_str(0, ":0100000055AA", 0);
        idle(2);
        checks++;
        if (q16_addr.size() != 1 || q16_addr[0] !== 32'h0000 || q16_data[0] !== 8'h55 || err_cs16 !== 1'b0) begin
            errors++;
            $display("FAIL fmt_recover got n=%0d cs=%b want one write (0000,55) cs=0", q16_addr.size(), err_cs16);
        end
        do_reset();
        send_str(0, ":0100", 0);
        checks++;
        if (err_fmt16 !== 1'b0) begin
            errors++;
            $display("FAIL fmt_early got fmt=%b want 0", err_fmt16);
        end
        send_str(0, ":0100000055AA", 0);
        idle(2);
        checks++;
        if (err_fmt16 !== 1'b1 || q16_addr.size() != 1 || q16_data[0] !== 8'h55) begin
            errors++;
            $display("FAIL fmt_truncated got fmt=%b writes=%0d want fmt=1 one write", err_fmt16, q16_addr.size());
        end
        do_reset();
        send_str(0, ":0000000600", 0);
        checks++;
        if (err_fmt16 !== 1'b1) begin
            errors++;
            $display("FAIL fmt_bad_type got fmt=%b want 1", err_fmt16);
        end
    endtask

    task automatic test_reset_mid_record();
        do_reset();
        send_str(0, ":03001000112", 0);
        @(negedge clock);
        drive(0, 1'b1, 8'h32);
        reset = 1'b1;
        @(negedge clock);
        drive(0, 1'b0, 8'h00);
        checks++;
        if ({bus16.mem_we, bus16.mem_addr, bus16.mem_data, done16, err_cs16, err_fmt16} !== 28'd0) begin
            errors++;
            $display("FAIL midreset_outputs got we=%b addr=%h data=%h want all 0",
                     bus16.mem_we, bus16.mem_addr, bus16.mem_data);
        end
        checks++;
        if (q16_addr.size() != 1 || q16_addr[0] !== 32'h0010) begin
            errors++;
            $display("FAIL midreset_dropped got writes=%0d want 1 (second write dropped)", q16_addr.size());
        end
        reset = 1'b0;
        q16_addr.delete(); q16_data.delete(); q16_cyc.delete();
        send_str(0, ":0300100011223387", 0);
        idle(2);
        checks++;
        if (q16_addr.size() != 3 || q16_addr[2] !== 32'h0012 || q16_data[2] !== 8'h33 ||
            err_fmt16 !== 1'b0 || err_cs16 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_recover got n=%0d fmt=%b cs=%b want 3 writes no errors",
                     q16_addr.size(), err_fmt16, err_cs16);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        test_reset();
        test_data_record();
        test_eof();
        test_checksum_error();
        test_back_to_back();
        test_ext_addr();
        test_format_error();
        test_reset_mid_record();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ihex_decoder.md
# ihex_decoder

Parses an Intel HEX character stream arriving one ASCII byte at a time from the UART receiver and turns data records into single-byte memory write strobes. It sits between `uart_rx` (`we_out`/`data_out`) and the target memory or loader. It verifies per-record checksums, tracks extended linear addressing, and flags end-of-file and error conditions.

## Interface

Parameters:
- ADDR_W, default 16: width of `mem_addr`. Legal range is 16..32. Bits above 15 come from type-04 records.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- we_in  in  1  one-cycle strobe; `data_in` is valid; may assert on consecutive cycles
- data_in  in  8  ASCII character
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write address
- mem_data  out  8  write data
- done  out  1  valid EOF record seen; cleared by the next ':' or by reset
- err_checksum  out  1  sticky; cleared only by reset
- err_format  out  1  sticky; cleared only by reset

## Operation

- Reset: all outputs 0, state IDLE, upper address register 0, nibble flag 0, running sum 0.
- States: IDLE, LEN, ADDR_HI, ADDR_LO, TYPE, DATA, CSUM.
- Every state except IDLE consumes two hex characters, high nibble first.
- Hex characters: 0x30-0x39, 0x41-0x46, 0x61-0x66. Any other character inside a record sets err_format and returns to IDLE; the record is discarded.
- IDLE ignores every character except ':'.
- ':' in any state: clears done, sum, nibble flag and byte counter, then moves to LEN. A ':' outside IDLE also sets err_format (truncated record).
- Sum: 8-bit modulo sum of LEN, ADDR_HI, ADDR_LO, TYPE, all data bytes and the checksum byte. The record is valid iff the sum is 0x00.
- TYPE transition: goes to DATA if LEN≠0, otherwise to CSUM.
  - Types 00-05 are accepted.
  - Type >05 sets err_format and returns to IDLE.
- DATA, type 00:
  - Each completed byte issues a mem_we pulse.
  - mem_addr = {upper[ADDR_W-17:0], (rec_addr + index) mod 2^16}. The low 16 bits wrap within the record.
  - Writes are issued before checksum verification; a checksum failure does not roll them back.
- DATA, type 04:
  - LEN must be 2, else err_format and return to IDLE.
  - The two bytes (big-endian) are held pending and latch into the upper register only on a valid checksum.
  - With ADDR_W=16 the record is accepted and has no effect.
- DATA, types 02/03/05: bytes are summed only; no effect.
- Type 01: LEN must be 0, else err_format. A valid checksum sets done.
- CSUM: on the second nibble, evaluate the sum.
  - Nonzero sum sets err_checksum and suppresses the done/upper-address update.
  - Next state is IDLE; trailing CR/LF is ignored there.
- No backpressure: one character is processed per we_in cycle.

## Timing

- All outputs are registered.
- For the cycle N in which the second nibble of a data byte is accepted:
  - mem_we is high in cycle N+1 only.
  - mem_addr and mem_data are valid in cycle N+1 and hold until the next write.
- done, err_checksum, err_format and the upper-address update take effect in cycle N+1 after the terminating character.
- Back-to-back we_in, one per cycle, produces mem_we pulses at most every other cycle, because each byte takes two characters.
- Reset asserted mid-record: the next cycle is IDLE with all outputs 0. A mem_we due in that cycle is dropped.

## Test plan

- ":0300100011223387" with ADDR_W=16 -> exactly three writes: (0x0010,0x11), (0x0011,0x22), (0x0012,0x33); no error flags.
- ":00000001FF" -> done=1 in the cycle after the final 'F'; no mem_we. A subsequent ':' clears done.
- ":0100000055AB" (correct checksum is AA) -> one write (0x0000,0x55), then err_checksum=1 and done stays 0.
- ":02FFFF00aabb9B" with lowercase hex and we_in every cycle -> writes (0xFFFF,0xAA) then (0x0000,0xBB); no errors.
- ADDR_W=32: ":020000040001F9" then ":0100000055AA" -> a single write (0x00010000,0x55). Repeat with ":020000040001F8" first -> err_checksum=1 and the write goes to 0x00000000.
- ":01G0" -> err_format=1 and no writes; a following ":0100000055AA" -> write (0x0000,0x55). Reset asserted mid-record -> all outputs 0, then the next record decodes normally.
